// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: widths, immediate-type encodings,
// skid-buffer state encoding and the entry record held by the imm stage.
// Optional feature macro: IMM_GEN_ILLEGAL_FLAG_EN (adds the illegal flag to each entry).
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [2:0] {
        IMM_I       = 3'b000,
        IMM_S       = 3'b001,
        IMM_B       = 3'b010,
        IMM_U       = 3'b011,
        IMM_J       = 3'b100,
        IMM_INVALID = 3'b111
    } imm_type_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    // One pipeline entry; the immediate is stored already expanded so the
    // output side never recomputes it.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      immType;
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
        logic            illegal;
`endif
    } stage_entry_t;

    // Anything outside the five defined formats counts as illegal.
    function automatic logic isIllegalType(input logic [2:0] t);
        return (t > 3'd4);
    endfunction

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate generator: raw instruction plus immediate type in,
// sign-extended XLEN-wide immediate out. Undefined types yield zero.
module imm_gen_core
    import riscv_pkg::*;
(
    input  logic [ILEN-1:0] instr_i,
    input  logic [2:0]      immType_i,
    output logic [XLEN-1:0] imm_o
);

    logic signBit;
    logic unusedOpcode;

    assign signBit      = instr_i[31];
    assign unusedOpcode = ^instr_i[6:0];

    // Gather the scattered immediate fields and replicate instr[31] upwards.
    always_comb begin
        imm_o = '0;
        case (immType_i)
            IMM_I: imm_o = {{(XLEN-12){signBit}}, instr_i[31:20]};
            IMM_S: imm_o = {{(XLEN-12){signBit}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{(XLEN-13){signBit}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {{(XLEN-32){signBit}}, instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{(XLEN-21){signBit}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage with a registered valid/ready output
// and a two-entry skid buffer (main + skid register). in_ready is decoded
// purely from the registered skid state, so out_ready never reaches it
// combinationally. Optional macro IMM_GEN_ILLEGAL_FLAG_EN adds out_illegal.
module imm_gen_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_imm_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
    ,
    output logic            out_illegal
`endif
);

    skid_state_t  state_q, state_d;
    stage_entry_t main_q, main_d;
    stage_entry_t skid_q, skid_d;
    stage_entry_t newEntry;
    logic [XLEN-1:0] newImm;
    logic accept;
    logic drain;

    imm_gen_core u_core (
        .instr_i   (in_instr),
        .immType_i (in_imm_type),
        .imm_o     (newImm)
    );

    // Build the entry to capture: immediate is expanded here, at input time.
    always_comb begin
        newEntry         = '0;
        newEntry.instr   = in_instr;
        newEntry.pc      = in_pc;
        newEntry.imm     = newImm;
        newEntry.immType = in_imm_type;
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
        newEntry.illegal = isIllegalType(in_imm_type);
`endif
    end

    assign in_ready  = (state_q != SKID_TWO);
    assign out_valid = (state_q != SKID_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    assign out_instr    = main_q.instr;
    assign out_pc       = main_q.pc;
    assign out_imm      = main_q.imm;
    assign out_imm_type = main_q.immType;
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
    assign out_illegal  = main_q.illegal;
`endif

    // Skid control: a flush wins over everything; otherwise fill main first,
    // spill into skid only when the consumer stalls, and promote skid on drain.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        main_d  = newEntry;
                        state_d = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && drain) begin
                        main_d = newEntry;
                    end else if (accept) begin
                        skid_d  = newEntry;
                        state_d = SKID_TWO;
                    end else if (drain) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // State and entry registers; reset empties the stage and zeroes all data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
